// File: rtl/rcb_frl_training_detector_pkg.sv
// Shared definitions for the FRL training detector and the transmit-side pattern generator.
package rcb_frl_training_detector_pkg;

    localparam logic [7:0] TRAIN_A = 8'hF4;
    localparam logic [7:0] TRAIN_B = 8'hC2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_SLIP_WAIT,
        S_LOCKED,
        S_FAIL
    } state_t;

endpackage

// File: rtl/rcb_frl_training_detector_if.sv
// Receive-byte input and alignment status/control bundle of the training detector.
interface rcb_frl_training_detector_if;

    logic       EN;
    logic [7:0] DATA_IN;
    logic       BITSLIP;
    logic       LOCKED;
    logic       FAIL;
    logic [3:0] SLIP_CNT;

    modport master (output EN, DATA_IN, input BITSLIP, LOCKED, FAIL, SLIP_CNT);
    modport slave  (input EN, DATA_IN, output BITSLIP, LOCKED, FAIL, SLIP_CNT);

endinterface

// File: rtl/rcb_frl_train_match.sv
// Classifies each received byte against the strictly alternating F4/C2 training pattern.
module rcb_frl_train_match
    import rcb_frl_training_detector_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       restart,
    input  logic       sample,
    input  logic [7:0] data,
    output logic       match
);

    logic [7:0] prev;
    logic       prev_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev       <= 8'h00;
            prev_valid <= 1'b0;
        end else begin
            prev <= data;
            if (restart)
                prev_valid <= 1'b0;
            else if (sample)
                prev_valid <= 1'b1;
        end
    end

    // Two identical training bytes in a row mean the word boundary is wrong.
    assign match = ((data == TRAIN_A) || (data == TRAIN_B)) &&
                   (!prev_valid || (data != prev));

endmodule

// File: rtl/rcb_frl_training_detector.sv
// Word-alignment FSM: hunts for the training pattern with bitslips, then tracks lock.
module rcb_frl_training_detector
    import rcb_frl_training_detector_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 4,
    parameter int SLIP_WAIT  = 4,
    parameter int MAX_SLIPS  = 8
)(
    input logic                        CLK,
    input logic                        RST,
    rcb_frl_training_detector_if.slave bus
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);
    localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);

    localparam logic [MATCH_W-1:0] MATCH_SAT  = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0]  MISS_SAT   = MISS_W'(LOSS_COUNT);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_COUNT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(SLIP_WAIT);
    localparam logic [3:0]         SLIP_SAT   = 4'(MAX_SLIPS);

    state_t             state, state_next;
    logic               slip_req;
    logic               match;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [3:0]         slip_cnt;
    logic               bitslip_q, locked_q, fail_q;

    rcb_frl_train_match u_match (
        .CLK     (CLK),
        .RST     (RST),
        .restart ((state_next == S_SEARCH) && (state != S_SEARCH)),
        .sample  ((state == S_SEARCH) || (state == S_LOCKED)),
        .data    (bus.DATA_IN),
        .match   (match)
    );

    always_comb begin
        state_next = state;
        slip_req   = 1'b0;
        case (state)
            S_IDLE:
                if (bus.EN) state_next = S_SEARCH;
            S_SEARCH:
                if (match) begin
                    if (match_cnt == MATCH_LAST) state_next = S_LOCKED;
                end else if (slip_cnt != SLIP_SAT) begin
                    slip_req   = 1'b1;
                    state_next = S_SLIP_WAIT;
                end else begin
                    state_next = S_FAIL;
                end
            S_SLIP_WAIT:
                if (wait_cnt == WAIT_LAST) state_next = S_SEARCH;
            S_LOCKED:
                if (!match && (miss_cnt == MISS_LAST)) state_next = S_SEARCH;
            S_FAIL:
                state_next = S_FAIL;
            default:
                state_next = S_IDLE;
        endcase
        if (!bus.EN) begin
            state_next = S_IDLE;
            slip_req   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            match_cnt <= '0;
            miss_cnt  <= '0;
            wait_cnt  <= '0;
            slip_cnt  <= '0;
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state     <= state_next;
            bitslip_q <= slip_req;
            locked_q  <= (state_next == S_LOCKED);
            fail_q    <= (state_next == S_FAIL);
            // The bitslip cycle itself is not part of the settle window, hence SLIP_WAIT+1 cycles.
            wait_cnt  <= ((state == S_SLIP_WAIT) && (wait_cnt != WAIT_LAST)) ?
                         wait_cnt + WAIT_W'(1) : '0;
            if (state_next == S_IDLE) begin
                match_cnt <= '0;
                miss_cnt  <= '0;
                slip_cnt  <= '0;
            end else begin
                case (state)
                    S_SEARCH:
                        if (match) begin
                            if (match_cnt != MATCH_SAT) match_cnt <= match_cnt + MATCH_W'(1);
                        end else if (slip_req) begin
                            match_cnt <= '0;
                            slip_cnt  <= slip_cnt + 4'd1;
                        end
                    S_LOCKED:
                        if (match) begin
                            miss_cnt <= '0;
                        end else if (state_next == S_SEARCH) begin
                            miss_cnt  <= '0;
                            match_cnt <= '0;
                            slip_cnt  <= '0;
                        end else if (miss_cnt != MISS_SAT) begin
                            miss_cnt <= miss_cnt + MISS_W'(1);
                        end
                    default: ;
                endcase
            end
        end
    end

    assign bus.BITSLIP  = bitslip_q;
    assign bus.LOCKED   = locked_q;
    assign bus.FAIL     = fail_q;
    assign bus.SLIP_CNT = slip_cnt;

endmodule

// File: tb/tb_rcb_frl_training_detector.sv
// Directed scenarios for the FRL training detector with a simple bitslipping deserializer model.
module tb_rcb_frl_training_detector;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;

    int off, n, pulses, min_gap, last_pulse;

    rcb_frl_training_detector_if bus ();

    rcb_frl_training_detector dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Byte seen by the deserializer starting at bit position pos of the repeating F4,C2 serial stream.
    function automatic logic [7:0] byte_at(input int pos);
        logic [15:0] pat;
        logic [7:0]  r;
        pat = 16'hF4C2;
        for (int i = 0; i < 8; i++) r[7-i] = pat[15 - ((pos + i) % 16)];
        return r;
    endfunction

    task automatic step(input logic [7:0] d);
        bus.DATA_IN = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        bus.EN = 1'b0;
        step(8'h00);
        step(8'h00);
        RST = 1'b0;
    endtask

    task automatic clear_model(input int start_off);
        off = start_off; n = 0; pulses = 0; min_gap = 1000; last_pulse = -1;
    endtask

    // Deserializer model: every BITSLIP advances the word boundary by one bit.
    task automatic run_model(input int max_steps, input logic stop_on_fail);
        for (int k = 0; k < max_steps; k++) begin
            if (bus.LOCKED || (stop_on_fail && bus.FAIL)) break;
            step(stop_on_fail ? 8'h00 : byte_at(8 * n + off));
            n++;
            if (bus.BITSLIP) begin
                if (last_pulse >= 0 && (k - last_pulse) < min_gap) min_gap = k - last_pulse;
                last_pulse = k;
                pulses++;
                off = (off + 1) % 16;
            end
        end
    endtask

    task automatic test_reset();
        RST    = 1'b1;
        bus.EN = 1'b1;
        step(8'hF4);
        step(8'hC2);
        n_checks++;
        if (bus.BITSLIP !== 1'b0) begin n_fail++; $display("FAIL reset_bitslip: got %b want 0", bus.BITSLIP); end
        n_checks++;
        if (bus.LOCKED !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", bus.LOCKED); end
        n_checks++;
        if (bus.FAIL !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b want 0", bus.FAIL); end
        n_checks++;
        if (bus.SLIP_CNT !== 4'd0) begin n_fail++; $display("FAIL reset_slip_cnt: got %0d want 0", bus.SLIP_CNT); end
        RST = 1'b0;
    endtask

    task automatic test_aligned_lock();
        int slips;
        slips = 0;
        do_reset();
        bus.EN = 1'b1;
        step(8'h00);
        for (int i = 0; i < 16; i++) begin
            step(byte_at(8 * i));
            if (bus.BITSLIP) slips++;
            if (i == 14) begin
                n_checks++;
                if (bus.LOCKED !== 1'b0) begin n_fail++; $display("FAIL aligned_early_lock: got %b want 0 after 15 matches", bus.LOCKED); end
            end
        end
        n_checks++;
        if (bus.LOCKED !== 1'b1) begin n_fail++; $display("FAIL aligned_lock: got %b want 1 after 16 matches", bus.LOCKED); end
        n_checks++;
        if (slips !== 0) begin n_fail++; $display("FAIL aligned_bitslips: got %0d want 0", slips); end
        n_checks++;
        if (bus.SLIP_CNT !== 4'd0) begin n_fail++; $display("FAIL aligned_slip_cnt: got %0d want 0", bus.SLIP_CNT); end
    endtask

    task automatic test_rotated_lock();
        do_reset();
        bus.EN = 1'b1;
        step(8'h00);
        clear_model(13);
        run_model(200, 1'b0);
        n_checks++;
        if (bus.LOCKED !== 1'b1) begin n_fail++; $display("FAIL rotated_lock: got %b want 1", bus.LOCKED); end
        n_checks++;
        if (pulses !== 3) begin n_fail++; $display("FAIL rotated_pulses: got %0d want 3", pulses); end
        n_checks++;
        if (min_gap < 5) begin n_fail++; $display("FAIL rotated_gap: got %0d want >=5", min_gap); end
        n_checks++;
        if (bus.SLIP_CNT !== 4'd3) begin n_fail++; $display("FAIL rotated_slip_cnt: got %0d want 3", bus.SLIP_CNT); end
    endtask

    task automatic test_fail_exhaust();
        logic held;
        do_reset();
        bus.EN = 1'b1;
        step(8'h00);
        clear_model(0);
        run_model(300, 1'b1);
        n_checks++;
        if (bus.FAIL !== 1'b1) begin n_fail++; $display("FAIL exhaust_fail: got %b want 1", bus.FAIL); end
        n_checks++;
        if (pulses !== 8) begin n_fail++; $display("FAIL exhaust_pulses: got %0d want 8", pulses); end
        n_checks++;
        if (min_gap < 5) begin n_fail++; $display("FAIL exhaust_gap: got %0d want >=5", min_gap); end
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(8'h00);
            if (bus.FAIL !== 1'b1 || bus.BITSLIP !== 1'b0) held = 1'b0;
        end
        n_checks++;
        if (held !== 1'b1) begin n_fail++; $display("FAIL exhaust_hold: got %b want FAIL held with no BITSLIP", held); end
        n_checks++;
        if (bus.SLIP_CNT !== 4'd8) begin n_fail++; $display("FAIL exhaust_slip_cnt: got %0d want 8", bus.SLIP_CNT); end
        bus.EN = 1'b0;
        step(8'h00);
        n_checks++;
        if (bus.FAIL !== 1'b0) begin n_fail++; $display("FAIL exhaust_disable: got %b want 0", bus.FAIL); end
        n_checks++;
        if (bus.SLIP_CNT !== 4'd0) begin n_fail++; $display("FAIL exhaust_idle_cnt: got %0d want 0", bus.SLIP_CNT); end
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        bus.EN = 1'b1;
        step(8'h00);
        for (int i = 0; i < 16; i++) step(byte_at(8 * i));
        for (int i = 0; i < 3; i++) step(8'h00);
        n_checks++;
        if (bus.LOCKED !== 1'b1) begin n_fail++; $display("FAIL loss_three_bad: got %b want 1", bus.LOCKED); end
        step(8'hF4); step(8'hC2); step(8'hF4);
        for (int i = 0; i < 3; i++) step(8'h00);
        n_checks++;
        if (bus.LOCKED !== 1'b1) begin n_fail++; $display("FAIL loss_miss_cleared: got %b want 1", bus.LOCKED); end
        step(8'h00);
        n_checks++;
        if (bus.LOCKED !== 1'b0) begin n_fail++; $display("FAIL loss_four_bad: got %b want 0", bus.LOCKED); end
        n_checks++;
        if (bus.FAIL !== 1'b0 || bus.BITSLIP !== 1'b0) begin
            n_fail++; $display("FAIL loss_state: FAIL=%b BITSLIP=%b want 0 0", bus.FAIL, bus.BITSLIP);
        end
        for (int i = 0; i < 16; i++) step(byte_at(8 * i));
        n_checks++;
        if (bus.LOCKED !== 1'b1) begin n_fail++; $display("FAIL loss_relock: got %b want 1", bus.LOCKED); end
        bus.EN = 1'b0;
        step(8'hF4);
        n_checks++;
        if (bus.LOCKED !== 1'b0) begin n_fail++; $display("FAIL loss_disable: got %b want 0", bus.LOCKED); end
    endtask

    task automatic test_repeat_and_reset();
        do_reset();
        bus.EN = 1'b1;
        step(8'h00);
        step(8'hF4); step(8'hC2); step(8'hF4);
        n_checks++;
        if (bus.BITSLIP !== 1'b0) begin n_fail++; $display("FAIL repeat_no_slip: got %b want 0", bus.BITSLIP); end
        step(8'hF4);
        n_checks++;
        if (bus.BITSLIP !== 1'b1) begin n_fail++; $display("FAIL repeat_slip: got %b want 1", bus.BITSLIP); end
        n_checks++;
        if (bus.SLIP_CNT !== 4'd1) begin n_fail++; $display("FAIL repeat_slip_cnt: got %0d want 1", bus.SLIP_CNT); end
        step(8'h00);
        n_checks++;
        if (bus.BITSLIP !== 1'b0) begin n_fail++; $display("FAIL repeat_one_cycle: got %b want 0", bus.BITSLIP); end
        RST = 1'b1;
        step(8'h00);
        n_checks++;
        if ({bus.BITSLIP, bus.LOCKED, bus.FAIL, bus.SLIP_CNT} !== 7'd0) begin
            n_fail++;
            $display("FAIL wait_reset: got BITSLIP=%b LOCKED=%b FAIL=%b SLIP_CNT=%0d want all 0",
                     bus.BITSLIP, bus.LOCKED, bus.FAIL, bus.SLIP_CNT);
        end
        RST = 1'b0;
        step(8'h00);
        step(8'hC2);
        n_checks++;
        if (bus.BITSLIP !== 1'b0) begin n_fail++; $display("FAIL post_reset_search: got %b want 0", bus.BITSLIP); end
    endtask

    initial begin
        CLK         = 1'b0;
        RST         = 1'b1;
        bus.EN      = 1'b0;
        bus.DATA_IN = 8'h00;
        n_checks    = 0;
        n_fail      = 0;
        test_reset();
        test_aligned_lock();
        test_rotated_lock();
        test_fail_exhaust();
        test_loss_of_lock();
        test_repeat_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
